ro_cycle_meter: RTL and testbench

Synchronous edge counter that measures how often a ring oscillator toggles. The oscillator is built from a chain of inverter cells, and this block counts the rising edges of its tapped output over a programmable window of CLK cycles. It sits directly downstream of the inverter chain in the process-monitor macro. It hands a saturated count plus a sticky overflow flag to the test/readout logic through a START/DONE handshake.

---
 rtl/ro_cycle_meter_pkg.sv | 13 +
 rtl/ro_cycle_meter_if.sv | 26 ++
 rtl/ro_cycle_meter_edge_sync.sv | 29 ++
 rtl/ro_cycle_meter.sv | 89 ++++++++
 tb/tb_ro_cycle_meter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_cycle_meter_pkg.sv
// Shared types and default widths for the ring-oscillator cycle meter.
package ro_meter_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEAS,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ro_cycle_meter_if.sv
// START/DONE handshake and result bus between the meter and readout logic.
interface ro_cycle_meter_if
  import ro_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
);

  logic             START;
  logic [WIN_W-1:0] WIN;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] CNT;
  logic             OVF;

  modport master (
    output START, WIN,
    input  BUSY, DONE, CNT, OVF
  );

  modport slave (
    input  START, WIN,
    output BUSY, DONE, CNT, OVF
  );

endinterface

// File: rtl/ro_cycle_meter_edge_sync.sv
// Two-flop synchronizer plus edge flop for an asynchronous oscillator tap;
// EDGE is a one-cycle pulse per synchronized rising transition.
module ro_edge_sync (
  input  logic CLK,
  input  logic RN,
  input  logic RO,
  output logic EDGE
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Free-running sampling chain; only reset clears it.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= RO;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign EDGE = r_s2 & ~r_s3;

endmodule

// File: rtl/ro_cycle_meter.sv
// Counts synchronized rising edges of a ring-oscillator tap over a window
// of WIN clock cycles; result is a saturating count plus sticky overflow.
module ro_cycle_meter
  import ro_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
) (
  input  logic              CLK,
  input  logic              RN,
  inout  wire               VDD,
  inout  wire               VSS,
  input  logic              RO,
  ro_cycle_meter_if.slave   bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_edge;
  logic             w_unused_pwr;

  // Power pins carry no logic; fold them into a sink so they are referenced.
  assign w_unused_pwr = VDD ^ VSS;

  ro_edge_sync u_sync (
    .CLK  (CLK),
    .RN   (RN),
    .RO   (RO),
    .EDGE (w_edge)
  );

  // State register.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: IDLE and DONE both accept START; MEAS runs out the window.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.START) w_state_nxt = (bus.WIN != '0) ? ST_MEAS : ST_DONE;
      end
      ST_MEAS: begin
        if (r_win_cnt == WIN_W'(1)) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Window counter and saturating edge counter; frozen outside MEAS.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_win_cnt <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            r_win_cnt <= bus.WIN;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
          end
        end
        ST_MEAS: begin
          r_win_cnt <= r_win_cnt - WIN_W'(1);
          if (w_edge) begin
            if (r_cnt == '1) r_ovf <= 1'b1;
            else             r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_win_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.BUSY = (r_state == ST_MEAS);
  assign bus.DONE = (r_state == ST_DONE);
  assign bus.CNT  = r_cnt;
  assign bus.OVF  = r_ovf;

endmodule

// File: tb/tb_ro_cycle_meter.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop
// and compare on each rising DONE. A 16-bit and a 4-bit counter are tested.
module tb_ro_cycle_meter;

  logic       clk = 1'b0;
  logic       rn  = 1'b0;
  logic       ro  = 1'b0;
  logic       ro_static = 1'b0;
  logic [1:0] ro_ph = 2'd0;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    int unsigned cnt;
    int unsigned ovf;
    int unsigned busy;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t e16;
  exp_t e4;

  ro_cycle_meter_if #(.CNT_W(16), .WIN_W(16)) if16 ();
  ro_cycle_meter_if #(.CNT_W(4),  .WIN_W(16)) if4 ();

  ro_cycle_meter #(.CNT_W(16), .WIN_W(16)) dut16 (
    .CLK (clk), .RN (rn), .VDD (vdd), .VSS (vss), .RO (ro), .bus (if16)
  );

  ro_cycle_meter #(.CNT_W(4), .WIN_W(16)) dut4 (
    .CLK (clk), .RN (rn), .VDD (vdd), .VSS (vss), .RO (ro), .bus (if4)
  );

  always #5 clk = ~clk;

  // Oscillator model: 2 cycles high / 2 cycles low, changing 3 ns after the edge.
  always begin
    @(posedge clk);
    #3;
    ro_ph = ro_ph + 2'd1;
    ro    = ro_static ? 1'b1 : ro_ph[1];
  end

  function automatic void check(input string name, input int unsigned act,
                                input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor for the 16-bit meter.
  int unsigned busy16 = 0;
  logic        pd16   = 1'b0;
  always @(negedge clk) begin
    if (!rn) begin
      busy16 = 0;
      pd16   = 1'b0;
    end else begin
      if (if16.BUSY) busy16++;
      if (if16.DONE && !pd16) begin
        if (q16.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut16_unexpected_done: got DONE=1 expected no result");
        end else begin
          e16 = q16.pop_front();
          check("dut16_cnt",  if16.CNT, e16.cnt);
          check("dut16_ovf",  if16.OVF, e16.ovf);
          check("dut16_busy_cycles", busy16, e16.busy);
        end
        busy16 = 0;
      end
      pd16 = if16.DONE;
    end
  end

  // Monitor for the 4-bit meter.
  int unsigned busy4 = 0;
  logic        pd4   = 1'b0;
  always @(negedge clk) begin
    if (!rn) begin
      busy4 = 0;
      pd4   = 1'b0;
    end else begin
      if (if4.BUSY) busy4++;
      if (if4.DONE && !pd4) begin
        if (q4.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut4_unexpected_done: got DONE=1 expected no result");
        end else begin
          e4 = q4.pop_front();
          check("dut4_cnt",  if4.CNT, e4.cnt);
          check("dut4_ovf",  if4.OVF, e4.ovf);
          check("dut4_busy_cycles", busy4, e4.busy);
        end
        busy4 = 0;
      end
      pd4 = if4.DONE;
    end
  end

  task automatic start16(input int unsigned win, input bit push,
                         input int unsigned ecnt, input int unsigned eovf);
    exp_t e;
    e.cnt = ecnt; e.ovf = eovf; e.busy = win;
    if (push) q16.push_back(e);
    @(negedge clk);
    if16.START = 1'b1;
    if16.WIN   = 16'(win);
    @(negedge clk);
    if16.START = 1'b0;
  endtask

  task automatic start4(input int unsigned win, input int unsigned ecnt,
                        input int unsigned eovf);
    exp_t e;
    e.cnt = ecnt; e.ovf = eovf; e.busy = win;
    q4.push_back(e);
    @(negedge clk);
    if4.START = 1'b1;
    if4.WIN   = 16'(win);
    @(negedge clk);
    if4.START = 1'b0;
  endtask

  task automatic wait_done16(input int unsigned budget);
    int unsigned i = 0;
    while (!if16.DONE && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!if16.DONE) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut16_done_timeout: got DONE=0 expected DONE=1 within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  task automatic wait_done4(input int unsigned budget);
    int unsigned i = 0;
    while (!if4.DONE && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!if4.DONE) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut4_done_timeout: got DONE=0 expected DONE=1 within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if16.START = 1'b1;
    if16.WIN   = 16'd100;
    if4.START  = 1'b1;
    if4.WIN    = 16'd100;
    rn         = 1'b0;

    // Reset held with START asserted and RO toggling.
    repeat (6) @(negedge clk);
    check("rst_busy16", if16.BUSY, 0);
    check("rst_done16", if16.DONE, 0);
    check("rst_cnt16",  if16.CNT,  0);
    check("rst_ovf16",  if16.OVF,  0);
    check("rst_busy4",  if4.BUSY,  0);
    check("rst_done4",  if4.DONE,  0);

    if16.START = 1'b0;
    if4.START  = 1'b0;
    rn         = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy16", if16.BUSY, 0);
    check("idle_done16", if16.DONE, 0);

    // Zero window from IDLE: DONE one cycle after acceptance, no BUSY.
    start16(0, 1'b1, 0, 0);
    check("win0_done_next", if16.DONE, 1);
    check("win0_busy",      if16.BUSY, 0);
    @(negedge clk);

    // Nominal window.
    start16(100, 1'b1, 25, 0);
    wait_done16(150);

    // Saturating 4-bit counter, then back-to-back restart clears OVF.
    start4(100, 15, 1);
    wait_done4(150);
    start4(20, 5, 0);
    wait_done4(50);

    // Static-high oscillator produces no edges.
    ro_static = 1'b1;
    repeat (5) @(negedge clk);
    start16(50, 1'b1, 0, 0);
    wait_done16(80);
    ro_static = 1'b0;
    repeat (6) @(negedge clk);

    // START with a different WIN mid-window is ignored.
    start16(100, 1'b1, 25, 0);
    repeat (30) @(negedge clk);
    if16.START = 1'b1;
    if16.WIN   = 16'd50;
    @(negedge clk);
    if16.START = 1'b0;
    wait_done16(150);

    // Reset mid-window clears outputs without a clock edge.
    start16(100, 1'b0, 0, 0);
    repeat (29) @(negedge clk);
    #2;
    rn = 1'b0;
    #1;
    check("midrst_busy16", if16.BUSY, 0);
    check("midrst_done16", if16.DONE, 0);
    check("midrst_cnt16",  if16.CNT,  0);
    check("midrst_ovf16",  if16.OVF,  0);
    check("midrst_cnt4",   if4.CNT,   0);
    @(negedge clk);
    @(negedge clk);
    rn = 1'b1;
    repeat (3) @(negedge clk);
    start16(40, 1'b1, 10, 0);
    wait_done16(80);

    repeat (3) @(negedge clk);
    check("q16_drained", q16.size(), 0);
    check("q4_drained",  q4.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
